// File: rtl/pc_fetch_unit.sv
// Program counter / fetch-address stage with one MIPS branch delay slot and halt freeze.
// Latency: next sequential address 1 cycle after the edge; jump target 2 enabled cycles after the jump.
// Backpressure: clk_enable=0 stalls the stage and holds PC, pending target and state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_word,
    input  logic        Branch,
    input  logic        halt,
    input  logic [31:0] rs_data,
    output logic [31:0] instr_address,
    output logic [31:0] link_address,
    output logic        active,
    output logic        in_delay_slot
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DELAY  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] target_q;
    logic [31:0] target_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        is_jr;

    // rs_data[1:0] is deliberately dropped: JR targets are forced word-aligned.
    logic        unused_rs_low;
    assign unused_rs_low = ^rs_data[1:0];

    assign pc_plus4 = pc_q + 32'd4;

    // Opcode 0 with Branch asserted can only be JR; everything else is J/JAL.
    assign is_jr = (instr_word[31:26] == 6'd0);

    // Jump target formed from the instruction currently on the fetch bus.
    always_comb begin
        branch_target = '0;
        if (is_jr) begin
            branch_target = {rs_data[31:2], 2'b00};
        end else begin
            branch_target = {pc_plus4[31:28], instr_word[25:0], 2'b00};
        end
    end

    // Next-state logic: halt beats everything, a pending delay-slot target beats a new Branch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        if (clk_enable) begin
            unique case (state_q)
                ST_HALTED: begin
                    // Frozen until reset.
                end
                ST_RUN: begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (Branch) begin
                        pc_d     = pc_plus4;
                        target_d = branch_target;
                        state_d  = ST_DELAY;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_DELAY: begin
                    if (halt) begin
                        // Halting in the delay slot abandons the jump.
                        state_d  = ST_HALTED;
                        target_d = '0;
                    end else begin
                        // Any Branch seen in the slot is ignored; the earlier jump wins.
                        pc_d    = target_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register; reset takes precedence over clk_enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    assign instr_address = pc_q;
    assign link_address  = pc_q + 32'd8;
    assign active        = (state_q != ST_HALTED);
    assign in_delay_slot = (state_q == ST_DELAY);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes expected outputs, monitor compares on negedge.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic [31:0] instr_word = '0;
    logic        Branch = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] instr_address;
    logic [31:0] link_address;
    logic        active;
    logic        in_delay_slot;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .instr_word    (instr_word),
        .Branch        (Branch),
        .halt          (halt),
        .rs_data       (rs_data),
        .instr_address (instr_address),
        .link_address  (link_address),
        .active        (active),
        .in_delay_slot (in_delay_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] link;
        logic        act;
        logic        dly;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: current PC, an optional pending jump, and a halted flag.
    logic [31:0] m_pc = '0;
    logic [31:0] m_target = '0;
    bit          m_pending = 0;
    bit          m_halted = 0;

    task automatic model_edge(input bit rst, input bit en, input logic [31:0] iw,
                              input bit br, input bit hl, input logic [31:0] rs);
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RV; m_pending = 0; m_target = '0; m_halted = 0;
        end else if (en && !m_halted) begin
            if (hl) begin
                m_halted = 1; m_pending = 0;
            end else if (m_pending) begin
                m_pc = m_target; m_pending = 0;
            end else begin
                if (br) begin
                    if (iw[31:26] == 6'd0) tgt = rs & 32'hFFFF_FFFC;
                    else tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
                    m_target = tgt; m_pending = 1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: apply inputs, let the edge happen, push the expected outputs.
    // With chk set, the expectation is the hand-computed constant instead of the model.
    task automatic step(input bit rst, input bit en, input logic [31:0] iw,
                        input bit br, input bit hl, input logic [31:0] rs,
                        input bit chk, input logic [31:0] ea, input bit eact, input bit edly);
        exp_t e;
        reset = rst; clk_enable = en; instr_word = iw; Branch = br; halt = hl; rs_data = rs;
        @(posedge clk);
        model_edge(rst, en, iw, br, hl, rs);
        #1;
        if (chk) begin
            e.addr = ea; e.link = ea + 32'd8; e.act = eact; e.dly = edly;
        end else begin
            e.addr = m_pc; e.link = m_pc + 32'd8; e.act = !m_halted; e.dly = m_pending;
        end
        exp_q.push_back(e);
    endtask

    task automatic nop(input logic [31:0] ea);
        step(0, 1, 32'h0, 0, 0, 32'h0, 1, ea, 1, 0);
    endtask

    task automatic do_reset();
        step(1, $urandom_range(1), 32'h0, 0, 0, 32'h0, 1, RV, 1, 0);
    endtask

    // Monitor: every cycle presents an output; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (instr_address !== e.addr) begin
                    n_bad++;
                    $display("FAIL instr_address: got %h expected %h at %0t", instr_address, e.addr, $time);
                end
                n_cmp++;
                if (link_address !== e.link) begin
                    n_bad++;
                    $display("FAIL link_address: got %h expected %h at %0t", link_address, e.link, $time);
                end
                n_cmp++;
                if (active !== e.act) begin
                    n_bad++;
                    $display("FAIL active: got %b expected %b at %0t", active, e.act, $time);
                end
                n_cmp++;
                if (in_delay_slot !== e.dly) begin
                    n_bad++;
                    $display("FAIL in_delay_slot: got %b expected %b at %0t", in_delay_slot, e.dly, $time);
                end
            end
        end
    end

    initial begin
        // Reset and sequential fetch.
        do_reset();
        nop(32'hBFC00004);
        nop(32'hBFC00008);
        nop(32'hBFC0000C);
        nop(32'hBFC00010);
        // J at BFC00010.
        step(0, 1, 32'h08000100, 1, 0, 32'h0, 1, 32'hBFC00014, 1, 1);
        nop(32'hB0000400);
        nop(32'hB0000404);

        // JR at BFC00020 with misaligned rs.
        do_reset();
        for (int i = 1; i <= 8; i++) nop(RV + 32'(4 * i));
        step(0, 1, 32'h03E00008, 1, 0, 32'h00001237, 1, 32'hBFC00024, 1, 1);
        // A Branch in the delay slot must be ignored.
        step(0, 1, 32'h08000555, 1, 0, 32'h0, 1, 32'h00001234, 1, 0);

        // Stall while in the delay slot.
        do_reset();
        for (int i = 1; i <= 4; i++) nop(RV + 32'(4 * i));
        step(0, 1, 32'h08000100, 1, 0, 32'h0, 1, 32'hBFC00014, 1, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, $urandom, $urandom_range(1), 0, $urandom, 1, 32'hBFC00014, 1, 1);
        nop(32'hB0000400);

        // Halt at BFC00008, Branch toggling while halted, then reset.
        do_reset();
        nop(32'hBFC00004);
        nop(32'hBFC00008);
        step(0, 1, 32'hFC000000, 0, 1, 32'h0, 1, 32'hBFC00008, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 1, $urandom, i[0], $urandom_range(1), $urandom, 1, 32'hBFC00008, 0, 0);
        do_reset();

        // Halt in the delay slot: target never fetched.
        for (int i = 1; i <= 4; i++) nop(RV + 32'(4 * i));
        step(0, 1, 32'h08000100, 1, 0, 32'h0, 1, 32'hBFC00014, 1, 1);
        step(0, 1, 32'hFC000000, 0, 1, 32'h0, 1, 32'hBFC00014, 0, 0);
        for (int i = 0; i < 3; i++) nop_halted: step(0, 1, 32'h0, 0, 0, 32'h0, 1, 32'hBFC00014, 0, 0);

        // Reset in the delay slot discards the pending target.
        do_reset();
        for (int i = 1; i <= 4; i++) nop(RV + 32'(4 * i));
        step(0, 1, 32'h08000100, 1, 0, 32'h0, 1, 32'hBFC00014, 1, 1);
        do_reset();
        nop(32'hBFC00004);

        // 32-bit wrap: JR to FFFFFFFC, then sequential fetch wraps to 0.
        step(0, 1, 32'h00000008, 1, 0, 32'hFFFFFFFF, 1, 32'hBFC00008, 1, 1);
        step(0, 1, 32'h0, 0, 0, 32'h0, 1, 32'hFFFFFFFC, 1, 0);
        nop(32'h00000000);
        nop(32'h00000004);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] iw;
            iw = $urandom;
            if ($urandom_range(1) == 1) iw[31:26] = 6'd0;
            step($urandom_range(99) < 3, $urandom_range(99) < 80, iw,
                 $urandom_range(99) < 30, $urandom_range(99) < 2, $urandom,
                 0, 32'h0, 1, 0);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and fetch-address stage of the Harvard 5-instruction MIPS core.
- Sits directly upstream of the control decoder. It drives the instruction-memory address, and the fetched word goes to the decoder.
- Consumes the decoder's Branch and halt outputs and the instruction fields to form the next PC.
- Implements the MIPS single branch delay slot for J, JAL and JR, and freezes fetch on halt.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  when low, all state holds (stall).
- instr_word  input  32  instruction currently fetched from instruction memory.
- Branch  input  1  from control decoder; high for J/JAL (opcode 00001x) and JR (opcode 0, funct 001000).
- halt  input  1  from control decoder; high for opcode 111111.
- rs_data  input  32  register-file read of rs, used as the JR target.
- instr_address  output  32  current PC, driving the instruction-memory address.
- link_address  output  32  instr_address + 8, return address for JAL.
- active  output  1  high while the CPU executes; low once halted.
- in_delay_slot  output  1  high while the current instruction is a delay slot.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State machine: RUN, DELAY, HALTED. The PC register pc_q and the pending target target_q are 32 bits.
- Reset values (applied on the edge where reset=1, regardless of clk_enable or state):
  - pc_q=RESET_VECTOR, state=RUN, target_q=0.
  - Outputs: instr_address=RESET_VECTOR, active=1, in_delay_slot=0.
- Output decoding:
  - instr_address = pc_q, combinational from the register. Memory returns instr_word in the same cycle (Harvard, combinational read).
  - link_address = pc_q + 8, modulo 2^32.
  - active = (state != HALTED).
  - in_delay_slot = (state == DELAY).
- clk_enable=0 and reset=0: pc_q, target_q and state hold. Outputs are unchanged apart from combinational link_address.
- Target formation, evaluated combinationally from the current instr_word:
  - instr_word[31:26] == 0: target = {rs_data[31:2], 2'b00}. The low bits are forced to zero; no exception.
  - Otherwise: target = {pc_q_plus4[31:28], instr_word[25:0], 2'b00}, where pc_q_plus4 = pc_q + 4.
- Transitions (clk_enable=1, reset=0), in priority order:
  - HALTED: hold forever; pc_q frozen at the halt instruction address. Only reset exits.
  - Any state with halt=1: go to HALTED, pc_q unchanged. Halt in a delay slot discards target_q.
  - RUN with Branch=1: pc_q <= pc_q+4 (fetch the delay slot); target_q <= target; state <= DELAY.
  - RUN with Branch=0: pc_q <= pc_q+4.
  - DELAY: pc_q <= target_q; state <= RUN. A Branch seen in a delay slot is ignored, and the pending target_q is taken.
- Latency:
  - Sequential fetch: the next address appears 1 cycle after the edge.
  - Jump: target fetched 2 enabled cycles after the jump's fetch cycle (jump, delay slot, target).
- Arithmetic: all adds are 32-bit unsigned with wrap-around. 32'hFFFFFFFC+4 yields 0 with no error.
- Stall during DELAY: target_q is retained until an enabled edge occurs.
- Reset mid-operation (any state, including DELAY or HALTED): the next edge yields the full reset state, and the pending target is discarded.

Test Plan:
- Reset then 3 enabled cycles with NOP (32'h0, Branch=0) -> instr_address BFC00000, BFC00004, BFC00008, BFC0000C; active=1 throughout.
- J at BFC00010 with instr_word=32'h08000100, Branch=1 -> next BFC00014 with in_delay_slot=1, then B0000400, in_delay_slot=0.
- JR at BFC00020, rs_data=32'h00001237, Branch=1 -> BFC00024 (delay slot), then 00001234 (low bits cleared); link_address at the JR cycle = BFC00028.
- Stall: clk_enable=0 for 3 cycles in DELAY after a jump to B0000400 -> instr_address held at the delay-slot address, then B0000400 on the first enabled edge.
- halt=1 at BFC00008 -> active=0 next cycle, instr_address stays BFC00008 for 10 cycles despite Branch toggling. Reset=1 for one edge -> BFC00000, active=1.
- Halt in delay slot: jump then halt=1 in DELAY -> HALTED, instr_address frozen at the delay-slot address, target never fetched.
